seq_multiply: RTL and testbench

Sequential shift-and-add multiplier producing a full-width product of two WIDTH-bit operands in WIDTH iteration cycles. It is the companion of the team's sequential restoring divider and sits in the AXI memory-tester datapath. There it generates address strides and expected-data patterns, multiplying where the divider splits. The block has one multiply unit, a start/done handshake and a held result, and it uses no DSP inference.

---
 rtl/mem_tester_pkg.sv | 20 ++
 rtl/seq_multiply_step.sv | 23 ++
 rtl/seq_multiply.sv | 103 ++++++++++
 tb/tb_seq_multiply.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_tester_pkg.sv
// Shared types and sizing helpers for the AXI memory-tester datapath blocks.
package mem_tester_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Products are always twice the operand width.
  localparam int PROD_RATIO = 2;

  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

  function automatic int prod_width(input int w);
    return PROD_RATIO * w;
  endfunction

endpackage

// File: rtl/seq_multiply_step.sv
// One shift-and-add iteration: conditional add into acc, then right shift of {sum, mplr}.
module seq_multiply_step
  import mem_tester_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] mplr_i,
  input  logic [WIDTH-1:0] mcand_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] mplr_o
);

  logic [WIDTH:0] sum;

  // The carry bit lands in the top of acc after the shift, so nothing is lost.
  always_comb begin
    sum    = {1'b0, acc_i} + (mplr_i[0] ? {1'b0, mcand_i} : '0);
    acc_o  = sum[WIDTH:1];
    mplr_o = {sum[0], mplr_i[WIDTH-1:1]};
  end

endmodule

// File: rtl/seq_multiply.sv
// Sequential shift-and-add multiplier, WIDTH iterations per product, start/done handshake.
// Define SEQ_MULTIPLY_SIGNED_EN for a two's-complement build (magnitude multiply plus sign fix-up).
module seq_multiply
  import mem_tester_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] P,
  output state_t             state_o
);

  // Handshake: start is honoured only while busy=0; done pulses for one cycle
  // and P holds that product until the next done (or reset clears it).
  localparam int CW = cnt_width(WIDTH);
  localparam int PW = prod_width(WIDTH);

  state_t           state_q;
  logic [WIDTH-1:0] acc_q, mplr_q, mcand_q;
  logic [WIDTH-1:0] acc_d, mplr_d;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, done_q;
  logic [PW-1:0]    p_q;
  logic [WIDTH-1:0] a_load, b_load;
  logic [PW-1:0]    p_d;

  seq_multiply_step #(.WIDTH(WIDTH)) u_step (
    .acc_i   (acc_q),
    .mplr_i  (mplr_q),
    .mcand_i (mcand_q),
    .acc_o   (acc_d),
    .mplr_o  (mplr_d)
  );

`ifdef SEQ_MULTIPLY_SIGNED_EN
  logic neg_q;
  // Magnitude of the most negative value is 2^(WIDTH-1), which still fits unsigned.
  assign a_load = A[WIDTH-1] ? (~A + 1'b1) : A;
  assign b_load = B[WIDTH-1] ? (~B + 1'b1) : B;
  assign p_d    = neg_q ? (~{acc_d, mplr_d} + 1'b1) : {acc_d, mplr_d};
`else
  assign a_load = A;
  assign b_load = B;
  assign p_d    = {acc_d, mplr_d};
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      acc_q   <= '0;
      mplr_q  <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      p_q     <= '0;
`ifdef SEQ_MULTIPLY_SIGNED_EN
      neg_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            mcand_q <= a_load;
            mplr_q  <= b_load;
            acc_q   <= '0;
            cnt_q   <= CW'(WIDTH - 1);
            busy_q  <= 1'b1;
            state_q <= RUN;
`ifdef SEQ_MULTIPLY_SIGNED_EN
            neg_q   <= A[WIDTH-1] ^ B[WIDTH-1];
`endif
          end
        end
        RUN: begin
          acc_q  <= acc_d;
          mplr_q <= mplr_d;
          cnt_q  <= cnt_q - CW'(1);
          if (cnt_q == '0) begin
            p_q     <= p_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign P       = p_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_seq_multiply.sv
// Self-checking bench for seq_multiply at WIDTH=8; the reference follows SEQ_MULTIPLY_SIGNED_EN.
module tb_seq_multiply;
  import mem_tester_pkg::*;

  localparam int W = 8;

  logic           clk;
  logic           rstn;
  logic           start;
  logic [W-1:0]   A, B;
  logic           busy, done;
  logic [2*W-1:0] P;
  state_t         dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [2*W-1:0] exp_q[$];

  seq_multiply #(.WIDTH(W)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .start   (start),
    .A       (A),
    .B       (B),
    .busy    (busy),
    .done    (done),
    .P       (P),
    .state_o (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: plain arithmetic product in the active number system.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SEQ_MULTIPLY_SIGNED_EN
    logic signed [2*W-1:0] r;
    r = $signed(a) * $signed(b);
    return r;
`else
    logic [2*W-1:0] ua, ub;
    ua = {{W{1'b0}}, a};
    ub = {{W{1'b0}}, b};
    return ua * ub;
`endif
  endfunction

  // Driver: called at posedge+#1, returns at posedge+#1 one cycle after done.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input string name);
    bit seen;
    logic [2*W-1:0] exp;
    seen = 0;
    exp  = model(a, b);
    A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    exp_q.push_back(exp);
    n_checks++;
    if (busy !== 1'b1) begin
      n_errors++;
      $display("FAIL %s accept_busy: got %b want 1", name, busy);
    end
    for (int k = 1; k <= W + 3 && !seen; k++) begin
      @(posedge clk); #1;
      A = W'($urandom_range(0, 255));
      B = W'($urandom_range(0, 255));
      n_checks++;
      if (busy !== (k < W)) begin
        n_errors++;
        $display("FAIL %s busy_k%0d: got %b want %b", name, k, busy, (k < W));
      end
      if (done === 1'b1) begin
        seen = 1;
        n_checks++;
        if (k != W) begin
          n_errors++;
          $display("FAIL %s latency: got %0d want %0d edges", name, k, W);
        end
        n_checks++;
        if (P !== exp_q[0]) begin
          n_errors++;
          $display("FAIL %s product: got %h want %h", name, P, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
    if (!seen) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s timeout: no done within %0d edges", name, W + 3);
      exp_q.delete();
    end
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0 || P !== exp) begin
      n_errors++;
      $display("FAIL %s pulse_hold: done=%b P=%h want done=0 P=%h", name, done, P, exp);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; start = 1'b0; A = '0; B = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || P !== '0) begin
      n_errors++;
      $display("FAIL reset_values: busy=%b done=%b P=%h want 0 0 0000", busy, done, P);
    end
    n_checks++;
    if (dbg_state !== IDLE) begin
      n_errors++;
      $display("FAIL reset_state: got %0d want IDLE", dbg_state);
    end
    rstn = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || P !== '0) begin
      n_errors++;
      $display("FAIL idle_hold: busy=%b done=%b P=%h want 0 0 0000", busy, done, P);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] va[7] = '{8'd13, 8'd255, 8'd0,   8'd1,   8'hFD, 8'h80, 8'h7F};
    logic [W-1:0] vb[7] = '{8'd11, 8'd255, 8'hA5, 8'h80, 8'd5,  8'h80, 8'h80};
    for (int i = 0; i < 7; i++) run_op(va[i], vb[i], $sformatf("directed%0d", i));
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) begin
      run_op(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), $sformatf("random%0d", i));
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_back_to_back();
    int dn = 0;
    int k1 = -1;
    int k2 = -1;
    A = 8'd3; B = 8'd7; start = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(model(8'd3, 8'd7));
    for (int k = 1; k <= 2 * W + 4; k++) begin
      @(posedge clk); #1;
      if (k == 3) A = 8'd9;
      if (done === 1'b1) begin
        dn++;
        if (dn == 1) begin
          k1 = k;
          exp_q.push_back(model(8'd9, 8'd7));
        end else begin
          k2 = k;
        end
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL b2b_extra_done: done at edge %0d with nothing outstanding", k);
        end else begin
          if (P !== exp_q[0]) begin
            n_errors++;
            $display("FAIL b2b_product%0d: got %h want %h", dn, P, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
      end
      if (k == 2 * W + 1) start = 1'b0;
    end
    n_checks++;
    if (dn != 2 || k1 != W || k2 != 2 * W + 1) begin
      n_errors++;
      $display("FAIL b2b_timing: dones=%0d at %0d,%0d want 2 at %0d,%0d", dn, k1, k2, W, 2 * W + 1);
    end
    exp_q.delete();
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_start();
    logic [W-1:0] a, b;
    int dn = 0;
    a = W'($urandom_range(1, 255));
    b = W'($urandom_range(1, 255));
    A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 2 * W + 4; k++) begin
      @(posedge clk); #1;
      if (k == 4) begin
        start = 1'b1; A = ~a; B = ~b;
      end
      if (k == 5) start = 1'b0;
      if (done === 1'b1) dn++;
    end
    n_checks++;
    if (dn != 1) begin
      n_errors++;
      $display("FAIL ignore_done_count: got %0d want 1", dn);
    end
    n_checks++;
    if (P !== model(a, b)) begin
      n_errors++;
      $display("FAIL ignore_product: got %h want %h", P, model(a, b));
    end
  endtask

  task automatic test_reset_mid_run();
    int dn = 0;
    A = 8'd200; B = 8'd100; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || P !== '0) begin
      n_errors++;
      $display("FAIL abort_values: busy=%b done=%b P=%h want 0 0 0000", busy, done, P);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int k = 0; k < W + 3; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) dn++;
    end
    n_checks++;
    if (dn != 0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL abort_no_done: dones=%0d busy=%b want 0 0", dn, busy);
    end
    run_op(8'd2, 8'd3, "after_abort");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
